range_arbiter: RTL and testbench

Sequencer and round-robin arbiter that shares one `range_finder` instance among `N_REQ` sample-stream requesters. It grants one requester at a time and drives the finder's `start`, `data_in`, `data_in_valid` and `finish`. It captures the range result, returns it with the requester's ID and beat count, and re-arms the finder through its synchronous `clear`. It sits between the requester fabric and the single `range_finder` datapath.

---
 rtl/range_arbiter.sv | 161 ++++++++++++++++
 tb/tb_range_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/range_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// range_arbiter : round-robin sequencer sharing one range_finder among N_REQ
//                 sample streams.                               Rev 1.0
// ----------------------------------------------------------------------------
module range_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                clock,
  input  logic                clear_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [16*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ-1:0]    req_last,
  output logic [N_REQ-1:0]    req_ready,
  output logic                rf_clear,
  output logic                rf_start,
  output logic                rf_finish,
  output logic [15:0]         rf_data_in,
  output logic                rf_data_in_valid,
  input  logic                rf_range_valid,
  input  logic [15:0]         rf_range_value,
  output logic                result_valid,
  input  logic                result_ready,
  output logic [ID_W-1:0]     result_id,
  output logic [15:0]         result_value,
  output logic [15:0]         result_count
);

  typedef enum logic [2:0] {
    S_CLR    = 3'd0,
    S_IDLE   = 3'd1,
    S_START  = 3'd2,
    S_STREAM = 3'd3,
    S_FINISH = 3'd4,
    S_WAIT   = 3'd5,
    S_RESP   = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] grant_q, grant_d;
  logic [15:0]     count_q, count_d;
  logic [ID_W-1:0] res_id_q, res_id_d;
  logic [15:0]     res_val_q, res_val_d;
  logic [15:0]     res_cnt_q, res_cnt_d;

  logic [ID_W-1:0] w_pick;
  logic [15:0]     w_data;
  logic            w_valid;
  logic            w_last;

  // grant_q doubles as the round-robin pointer; nearest requester after it wins.
  always_comb begin
    w_pick = grant_q;
    for (int k = N_REQ; k >= 1; k--) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req[i] && (i == (int'(grant_q) + k) % N_REQ)) begin
          w_pick = ID_W'(i);
        end
      end
    end
  end

  always_comb begin
    w_data  = '0;
    w_valid = 1'b0;
    w_last  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q == ID_W'(i)) begin
        w_data  = req_data[16*i +: 16];
        w_valid = req_valid[i];
        w_last  = req_last[i];
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    count_d          = count_q;
    res_id_d         = res_id_q;
    res_val_d        = res_val_q;
    res_cnt_d        = res_cnt_q;
    req_ready        = '0;
    rf_clear         = 1'b0;
    rf_start         = 1'b0;
    rf_finish        = 1'b0;
    rf_data_in       = '0;
    rf_data_in_valid = 1'b0;
    result_valid     = 1'b0;
    case (state_q)
      S_CLR: begin
        rf_clear = 1'b1;
        state_d  = S_IDLE;
      end
      S_IDLE: begin
        if (|req) begin
          grant_d = w_pick;
          count_d = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        rf_start = 1'b1;
        state_d  = S_STREAM;
      end
      S_STREAM: begin
        req_ready        = {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;
        rf_data_in       = w_data;
        rf_data_in_valid = w_valid;
        if (w_valid) begin
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
          if (w_last) state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        rf_finish = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (rf_range_valid) begin
          res_id_d  = grant_q;
          res_val_d = rf_range_value;
          res_cnt_d = count_q;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        result_valid = 1'b1;
        // The finder only leaves its done state through clear, so always pass via CLR.
        if (result_ready) state_d = S_CLR;
      end
      default: state_d = S_CLR;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q   <= S_CLR;
      grant_q   <= ID_W'(N_REQ - 1);
      count_q   <= '0;
      res_id_q  <= '0;
      res_val_q <= '0;
      res_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      count_q   <= count_d;
      res_id_q  <= res_id_d;
      res_val_q <= res_val_d;
      res_cnt_q <= res_cnt_d;
    end
  end

  assign result_id    = res_id_q;
  assign result_value = res_val_q;
  assign result_count = res_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_range_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_range_arbiter : frame-level model and directed/random stimulus for
//                    range_arbiter with an attached range_finder model. Rev 1.0
// ----------------------------------------------------------------------------
module tb_range_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;

  logic              clock = 1'b0;
  logic              clear_n = 1'b0;
  logic [N-1:0]      req, req_valid, req_last, req_ready;
  logic [16*N-1:0]   req_data;
  logic              rf_clear, rf_start, rf_finish, rf_data_in_valid;
  logic              rf_range_valid, result_valid, result_ready;
  logic [15:0]       rf_data_in, rf_range_value, result_value, result_count;
  logic [IW-1:0]     result_id;

  always #5 clock = ~clock;

  range_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
    .clock(clock), .clear_n(clear_n),
    .req(req), .req_data(req_data), .req_valid(req_valid), .req_last(req_last),
    .req_ready(req_ready),
    .rf_clear(rf_clear), .rf_start(rf_start), .rf_finish(rf_finish),
    .rf_data_in(rf_data_in), .rf_data_in_valid(rf_data_in_valid),
    .rf_range_valid(rf_range_valid), .rf_range_value(rf_range_value),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_id(result_id), .result_value(result_value), .result_count(result_count)
  );

  // range_finder stand-in: done (and range valid) the cycle after finish
  logic [15:0] f_min = 16'hFFFF;
  logic [15:0] f_max = 16'h0000;
  logic        f_done = 1'b0;
  always @(posedge clock) begin
    if (rf_clear || rf_start) begin
      f_min <= 16'hFFFF; f_max <= 16'h0000; f_done <= 1'b0;
    end else if (!f_done) begin
      if (rf_data_in_valid) begin
        if (rf_data_in < f_min) f_min <= rf_data_in;
        if (rf_data_in > f_max) f_max <= rf_data_in;
      end
      if (rf_finish) f_done <= 1'b1;
    end
  end
  assign rf_range_valid = f_done;
  assign rf_range_value = f_max - f_min;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- requester lanes ----------------
  logic [15:0] lane_q [N][$];
  int          lane_pos [N];
  bit          cons [N];
  bit          stray = 1'b0;
  bit          auto_fill = 1'b0;
  int          gap = 0;
  int          rr_mode = 0;

  task automatic load_rand(input int i, input int len);
    for (int j = 0; j < len; j++)
      lane_q[i].push_back(($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom));
  endtask

  task automatic tick();
    @(negedge clock);
    for (int i = 0; i < N; i++) begin
      if (cons[i]) begin
        lane_pos[i]++;
        if (lane_pos[i] >= lane_q[i].size()) begin
          lane_q[i].delete();
          lane_pos[i] = 0;
          if (auto_fill) load_rand(i, $urandom_range(1, 3));
        end
      end
      cons[i] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      req[i] = lane_q[i].size() != 0;
      req_valid[i] = 1'b0;
      req_last[i] = 1'b0;
      req_data[16*i +: 16] = 16'h0;
      if (req_ready[i] && lane_q[i].size() != 0) begin
        req_valid[i] = $urandom_range(0, 99) >= gap;
        req_data[16*i +: 16] = lane_q[i][lane_pos[i]];
        req_last[i] = lane_pos[i] == lane_q[i].size() - 1;
        cons[i] = req_valid[i];
      end else if (stray) begin
        req_valid[i] = 1'($urandom);
        req_last[i] = 1'($urandom);
        req_data[16*i +: 16] = 16'($urandom);
      end
    end
    case (rr_mode)
      0: result_ready = 1'b1;
      1: result_ready = $urandom_range(0, 2) != 0;
      default: result_ready = 1'b0;
    endcase
  endtask

  // ---------------- frame-level reference model and compare ----------------
  int          exp_last = N - 1;
  int          exp_g = 0;
  bit          free_m = 0, start_due = 0, in_stream = 0, rv_exp = 0, acc_prev = 0, prev_cn = 0;
  int          since_last = -1;
  logic [15:0] e_val = 0, e_cnt = 0;
  int          e_id = 0;
  int          vc = 0, n_res = 0, clr_cnt = 0, last_beat_vc = 0, rise_vc = 0;
  int          last_id = 0;
  logic [15:0] last_val = 0, last_cnt = 0;
  int          acc_ids [$];
  bit          prev_rv = 0;

  always @(negedge clock) begin
    int c, pick, sz;
    logic [15:0] mn, mx;
    bit clr_e;
    #2;
    vc++;
    if (!clear_n) begin
      chk("rst_rf_clear", 32'(rf_clear), 1);
      chk("rst_outputs", 32'({req_ready, rf_start, rf_finish, rf_data_in_valid, rf_data_in, result_valid}), 0);
      chk("rst_result_id", 32'(result_id), 0);
      chk("rst_result_payload", {result_value, result_count}, 0);
      exp_last = N - 1; free_m = 0; start_due = 0; in_stream = 0; since_last = -1;
      rv_exp = 0; acc_prev = 0; prev_cn = 0; prev_rv = 0;
    end else begin
      clr_e = !prev_cn || acc_prev;
      chk("rf_clear", 32'(rf_clear), 32'(clr_e));
      chk("rf_start", 32'(rf_start), 32'(start_due));
      chk("req_ready", 32'(req_ready), in_stream ? (32'd1 << exp_g) : 32'd0);
      chk("rf_finish", 32'(rf_finish), 32'(since_last == 1));
      chk("result_valid", 32'(result_valid), 32'(rv_exp));
      if (in_stream) begin
        chk("rf_data_in_valid", 32'(rf_data_in_valid), 32'(req_valid[exp_g]));
        if (req_valid[exp_g]) chk("rf_data_in", 32'(rf_data_in), 32'(req_data[16*exp_g +: 16]));
      end else begin
        chk("rf_data_in_valid_off", 32'(rf_data_in_valid), 0);
      end
      if (rv_exp) begin
        chk("result_id", 32'(result_id), 32'(e_id));
        chk("result_value", 32'(result_value), 32'(e_val));
        chk("result_count", 32'(result_count), 32'(e_cnt));
      end
      if (rf_clear) clr_cnt++;
      if (result_valid && !prev_rv) rise_vc = vc;
      prev_rv = result_valid;

      if (rv_exp && result_ready) begin
        rv_exp = 0; acc_prev = 1; n_res++;
        last_id = int'(result_id); last_val = result_value; last_cnt = result_count;
        acc_ids.push_back(int'(result_id));
      end else begin
        acc_prev = 0;
      end
      if (since_last >= 1) begin
        since_last++;
        if (since_last == 3) begin rv_exp = 1; since_last = -1; end
      end
      if (in_stream && req_valid[exp_g] && req_last[exp_g]) begin
        in_stream = 0; since_last = 1; last_beat_vc = vc;
      end
      if (start_due) begin start_due = 0; in_stream = 1; end
      if (free_m && req != 0) begin
        pick = -1;
        for (int k = 1; k <= N; k++) begin
          c = (exp_last + k) % N;
          if (pick < 0 && req[c]) pick = c;
        end
        exp_g = pick; exp_last = pick; e_id = pick;
        mn = 16'hFFFF; mx = 16'h0000;
        sz = lane_q[pick].size();
        for (int j = 0; j < sz; j++) begin
          if (lane_q[pick][j] < mn) mn = lane_q[pick][j];
          if (lane_q[pick][j] > mx) mx = lane_q[pick][j];
        end
        e_val = mx - mn;
        e_cnt = (sz > 65535) ? 16'hFFFF : 16'(sz);
        start_due = 1; free_m = 0;
      end
      if (clr_e) free_m = 1;
      prev_cn = 1;
    end
  end

  // ---------------- sequencing helpers ----------------
  task automatic do_reset(input int cycles);
    @(negedge clock);
    clear_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      lane_q[i].delete(); lane_pos[i] = 0; cons[i] = 1'b0;
    end
    req = '0; req_valid = '0; req_last = '0; req_data = '0;
    repeat (cycles) @(negedge clock);
    clear_n = 1'b1;
  endtask

  task automatic wait_res(input int n, input int budget);
    int b = 0;
    while (n_res < n && b < budget) begin tick(); b++; end
    chk("result_timeout", 32'(n_res >= n), 1);
  endtask

  task automatic drain(input int budget);
    int b = 0;
    int pend = 1;
    while ((pend != 0 || result_valid) && b < budget) begin
      tick(); b++;
      pend = 0;
      for (int i = 0; i < N; i++) pend += lane_q[i].size();
    end
    chk("drain_timeout", 32'(b < budget), 1);
    repeat (5) tick();
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n0, clr0, b;
    req = '0; req_valid = '0; req_last = '0; req_data = '0; result_ready = 1'b1;
    for (int i = 0; i < N; i++) begin lane_pos[i] = 0; cons[i] = 1'b0; end
    repeat (3) @(negedge clock);
    clear_n = 1'b1;
    repeat (3) tick();

    // frame {5,20,12} on lane 0
    lane_q[0].push_back(16'd5); lane_q[0].push_back(16'd20); lane_q[0].push_back(16'd12);
    wait_res(1, 60);
    chk("t1_id", 32'(last_id), 0);
    chk("t1_value", 32'(last_val), 15);
    chk("t1_count", 32'(last_cnt), 3);
    chk("t1_latency", 32'(rise_vc - last_beat_vc), 3);

    // one-beat frame on lane 1
    lane_q[1].push_back(16'h1234);
    wait_res(2, 60);
    chk("t2_id", 32'(last_id), 1);
    chk("t2_value", 32'(last_val), 0);
    chk("t2_count", 32'(last_cnt), 1);

    // all requesters held with stray beats: grants 0,1,2,3,0 after reset
    do_reset(2);
    stray = 1'b1; auto_fill = 1'b1;
    for (int i = 0; i < N; i++) load_rand(i, $urandom_range(1, 3));
    base = acc_ids.size();
    wait_res(n_res + 5, 200);
    for (int k = 0; k < 5; k++) begin
      if (acc_ids.size() > base + k) chk("t3_grant_order", 32'(acc_ids[base + k]), 32'(k % N));
      else chk("t3_grant_missing", 32'(acc_ids.size()), 32'(base + k + 1));
    end
    auto_fill = 1'b0;
    drain(300);
    stray = 1'b0;

    // consumer stall: result held, no new grant, one clear after accept
    rr_mode = 2;
    lane_q[3].push_back(16'd7); lane_q[3].push_back(16'd3); lane_q[3].push_back(16'd9);
    b = 0;
    while (!result_valid && b < 40) begin tick(); b++; end
    chk("t4_rv_wait", 32'(result_valid), 1);
    lane_q[2].push_back(16'd1); lane_q[2].push_back(16'd2);
    repeat (10) tick();
    chk("t4_no_grant", 32'(req_ready), 0);
    chk("t4_held_value", 32'(result_value), 6);
    n0 = n_res; clr0 = clr_cnt;
    rr_mode = 0;
    wait_res(n0 + 1, 20);
    repeat (2) tick();
    chk("t4_clr_once", 32'(clr_cnt - clr0), 1);
    chk("t4_id", 32'(last_id), 3);
    chk("t4_count", 32'(last_cnt), 3);
    drain(100);

    // reset mid-stream discards the frame
    for (int j = 0; j < 10; j++) lane_q[1].push_back(16'(100 + j));
    b = 0;
    while (!req_ready[1] && b < 40) begin tick(); b++; end
    chk("t5_grant_wait", 32'(req_ready[1]), 1);
    repeat (3) tick();
    n0 = n_res;
    do_reset(2);
    repeat (10) tick();
    chk("t5_no_result", 32'(n_res), 32'(n0));
    lane_q[0].push_back(16'h0000); lane_q[0].push_back(16'hFFFF);
    wait_res(n0 + 1, 60);
    chk("t5_id", 32'(last_id), 0);
    chk("t5_value", 32'(last_val), 32'hFFFF);
    chk("t5_count", 32'(last_cnt), 2);

    // randomized traffic
    stray = 1'b1; gap = 30; rr_mode = 1;
    for (int t = 0; t < 600; t++) begin
      tick();
      for (int i = 0; i < N; i++)
        if (lane_q[i].size() == 0 && $urandom_range(0, 9) == 0) load_rand(i, $urandom_range(1, 6));
    end
    rr_mode = 0;
    drain(400);
    stray = 1'b0; gap = 0;

    // long frame saturates the count
    for (int k = 0; k < 70000; k++) lane_q[2].push_back(16'(100 + (k % 1000)));
    n0 = n_res;
    wait_res(n0 + 1, 70100);
    chk("t6_id", 32'(last_id), 2);
    chk("t6_count", 32'(last_cnt), 32'hFFFF);
    chk("t6_value", 32'(last_val), 999);
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
